// File: rtl/move_option_generator.sv
// move_option_generator
//   Computes the pseudo-legal destination mask for the piece on one square.
//   Directions are walked one target square per clock:
//   IDLE -> LOAD -> SCAN -> DONE -> IDLE.
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-low reset
//   update           in   start strobe, only accepted while ready=1
//   selectedPosition in   square to evaluate (rank*8 + file), taken with update
//   boardData        in   board, square s at [s*PIECE_W +: PIECE_W]
//                         bit3 = colour (1 = black), [2:0] = type, 0/7 = empty
//   ready            out  1 = idle, moveOptions valid
//   moveOptions      out  bit s set -> piece may move to square s
//   dbg_state        out  current FSM state (0 IDLE, 1 LOAD, 2 SCAN, 3 DONE)
//
// Handshake: update is a request that is taken only when ready=1 at the
//   rising edge. ready stays 0 until the mask is complete. The mask then
//   holds until the next accepted update.
//
// Configuration macro: PAWN_DOUBLE_STEP_EN adds the two-square pawn push
//   from the start rank (one extra SCAN cycle). When it is not defined,
//   pawns push one square only.
module move_option_generator #(
  parameter int PIECE_W  = 4,
  parameter int NUM_SQ   = 64,
  parameter bit SNAPSHOT = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      update,
  input  logic [5:0]                selectedPosition,
  input  logic [PIECE_W*NUM_SQ-1:0] boardData,
  output logic                      ready,
  output logic [NUM_SQ-1:0]         moveOptions,
  output logic [1:0]                dbg_state
);

  localparam int BW = PIECE_W * NUM_SQ;

`ifdef PAWN_DOUBLE_STEP_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SCAN = 2'd2, DONE = 2'd3} state_e;

  // Returns {dx, dy}, each a 4-bit two's-complement step, for ray idx.
  function automatic logic [7:0] dir_delta(input logic [2:0] ptype, input logic [2:0] idx,
                                           input logic black);
    logic [3:0] fwd;
    fwd = black ? 4'hF : 4'h1;
    dir_delta = 8'h00;
    case (ptype)
      3'd1: case (idx)                         // pawn: push, capture left, capture right
        3'd0:    dir_delta = {4'h0, fwd};
        3'd1:    dir_delta = {4'hF, fwd};
        default: dir_delta = {4'h1, fwd};
      endcase
      3'd2: case (idx)                         // knight
        3'd0:    dir_delta = {4'h1, 4'h2};
        3'd1:    dir_delta = {4'h2, 4'h1};
        3'd2:    dir_delta = {4'h2, 4'hF};
        3'd3:    dir_delta = {4'h1, 4'hE};
        3'd4:    dir_delta = {4'hF, 4'hE};
        3'd5:    dir_delta = {4'hE, 4'hF};
        3'd6:    dir_delta = {4'hE, 4'h1};
        default: dir_delta = {4'hF, 4'h2};
      endcase
      3'd3: case (idx)                         // bishop: NE, SE, SW, NW
        3'd0:    dir_delta = {4'h1, 4'h1};
        3'd1:    dir_delta = {4'h1, 4'hF};
        3'd2:    dir_delta = {4'hF, 4'hF};
        default: dir_delta = {4'hF, 4'h1};
      endcase
      3'd4: case (idx)                         // rook: N, E, S, W
        3'd0:    dir_delta = {4'h0, 4'h1};
        3'd1:    dir_delta = {4'h1, 4'h0};
        3'd2:    dir_delta = {4'h0, 4'hF};
        default: dir_delta = {4'hF, 4'h0};
      endcase
      default: case (idx)                      // queen/king: N clockwise to NW
        3'd0:    dir_delta = {4'h0, 4'h1};
        3'd1:    dir_delta = {4'h1, 4'h1};
        3'd2:    dir_delta = {4'h1, 4'h0};
        3'd3:    dir_delta = {4'h1, 4'hF};
        3'd4:    dir_delta = {4'h0, 4'hF};
        3'd5:    dir_delta = {4'hF, 4'hF};
        3'd6:    dir_delta = {4'hF, 4'h0};
        default: dir_delta = {4'hF, 4'h1};
      endcase
    endcase
  endfunction

  function automatic logic [2:0] last_dir(input logic [2:0] ptype);
    case (ptype)
      3'd1:       last_dir = 3'd2;
      3'd3, 3'd4: last_dir = 3'd3;
      default:    last_dir = 3'd7;
    endcase
  endfunction

  function automatic logic [PIECE_W-1:0] piece_at(input logic [BW-1:0] b, input logic [5:0] sq);
    piece_at = b[int'(sq)*PIECE_W +: PIECE_W];
  endfunction

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [NUM_SQ-1:0]   mask_q, mask_d;
  logic [5:0]          origin_q, origin_d;
  logic [PIECE_W-1:0]  piece_q, piece_d;
  logic [BW-1:0]       board_q, board_d;
  logic [2:0]          dir_q, dir_d;
  logic [3:0]          tgt_f_q, tgt_f_d;   // current target file, two's complement
  logic [3:0]          tgt_r_q, tgt_r_d;   // current target rank, two's complement
  logic                dbl_q, dbl_d;       // testing the two-square pawn push

  logic [BW-1:0]       board_src;
  logic [3:0]          org_f, org_r, nf, nr;
  logic [5:0]          tgt_sq;
  logic [PIECE_W-1:0]  tgt_pc, org_pc;
  logic                tgt_empty, tgt_enemy, off_board, slides, advance, hit;
  logic [7:0]          cur_d, nxt_d, first_d;

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    mask_d   = mask_q;
    origin_d = origin_q;
    piece_d  = piece_q;
    board_d  = board_q;
    dir_d    = dir_q;
    tgt_f_d  = tgt_f_q;
    tgt_r_d  = tgt_r_q;
    dbl_d    = dbl_q;
    advance  = 1'b0;
    hit      = 1'b0;

    board_src = SNAPSHOT ? board_q : boardData;
    org_f     = {1'b0, origin_q[2:0]};
    org_r     = {1'b0, origin_q[5:3]};
    tgt_sq    = {tgt_r_q[2:0], tgt_f_q[2:0]};
    tgt_pc    = piece_at(board_src, tgt_sq);
    org_pc    = piece_at(board_src, origin_q);
    tgt_empty = (tgt_pc[2:0] == 3'd0) || (tgt_pc[2:0] == 3'd7);
    tgt_enemy = !tgt_empty && (tgt_pc[3] != piece_q[3]);
    // Any coordinate outside 0..7 has bit 3 set, whether it went negative or past 7.
    off_board = tgt_f_q[3] | tgt_r_q[3];
    slides    = (piece_q[2:0] == 3'd3) || (piece_q[2:0] == 3'd4) || (piece_q[2:0] == 3'd5);
    cur_d     = dir_delta(piece_q[2:0], dir_q, piece_q[3]);
    nxt_d     = dir_delta(piece_q[2:0], dir_q + 3'd1, piece_q[3]);
    first_d   = dir_delta(org_pc[2:0], 3'd0, org_pc[3]);
    nf        = tgt_f_q + cur_d[7:4];
    nr        = tgt_r_q + cur_d[3:0];

    case (state_q)
      IDLE: begin
        if (update) begin
          origin_d = selectedPosition;
          if (SNAPSHOT) board_d = boardData;
          ready_d  = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        mask_d  = '0;
        dir_d   = 3'd0;
        dbl_d   = 1'b0;
        piece_d = org_pc;
        if ((org_pc[2:0] == 3'd0) || (org_pc[2:0] == 3'd7)) begin
          state_d = DONE;
        end else begin
          tgt_f_d = org_f + first_d[7:4];
          tgt_r_d = org_r + first_d[3:0];
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (off_board) begin
          advance = 1'b1;
        end else if (dbl_q) begin
          hit     = tgt_empty;
          dbl_d   = 1'b0;
          advance = 1'b1;
        end else if (piece_q[2:0] == 3'd1) begin
          if (dir_q == 3'd0) begin
            hit = tgt_empty;
            if (DBL_EN && tgt_empty && (org_r == (piece_q[3] ? 4'd6 : 4'd1))) begin
              dbl_d   = 1'b1;
              tgt_f_d = nf;
              tgt_r_d = nr;
            end else begin
              advance = 1'b1;
            end
          end else begin
            hit     = tgt_enemy;
            advance = 1'b1;
          end
        end else if (tgt_empty) begin
          hit = 1'b1;
          // Only continue the ray when the next square is on the board; otherwise the
          // off-board square would cost a wasted cycle.
          if (slides && !(nf[3] | nr[3])) begin
            tgt_f_d = nf;
            tgt_r_d = nr;
          end else begin
            advance = 1'b1;
          end
        end else begin
          hit     = tgt_enemy;
          advance = 1'b1;
        end

        if (hit) mask_d[tgt_sq] = 1'b1;

        if (advance) begin
          if (dir_q == last_dir(piece_q[2:0])) begin
            state_d = DONE;
          end else begin
            dir_d   = dir_q + 3'd1;
            tgt_f_d = org_f + nxt_d[7:4];
            tgt_r_d = org_r + nxt_d[3:0];
          end
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      mask_q   <= '0;
      origin_q <= '0;
      piece_q  <= '0;
      board_q  <= '0;
      dir_q    <= '0;
      tgt_f_q  <= '0;
      tgt_r_q  <= '0;
      dbl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      mask_q   <= mask_d;
      origin_q <= origin_d;
      piece_q  <= piece_d;
      board_q  <= board_d;
      dir_q    <= dir_d;
      tgt_f_q  <= tgt_f_d;
      tgt_r_q  <= tgt_r_d;
      dbl_q    <= dbl_d;
    end
  end

  assign ready       = ready_q;
  assign moveOptions = mask_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_move_option_generator.sv
// Testbench for move_option_generator: directed positions with hand-computed masks
// and latencies.
module tb_move_option_generator;

  logic         clk;
  logic         reset;
  logic         update;
  logic [5:0]   selectedPosition;
  logic [255:0] boardData;
  logic         ready;
  logic [63:0]  moveOptions;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  localparam logic [3:0] W_PAWN   = 4'h1;
  localparam logic [3:0] W_KNIGHT = 4'h2;
  localparam logic [3:0] W_BISHOP = 4'h3;
  localparam logic [3:0] W_ROOK   = 4'h4;
  localparam logic [3:0] W_KING   = 4'h6;
  localparam logic [3:0] B_PAWN   = 4'h9;
  localparam logic [3:0] B_QUEEN  = 4'hD;

`ifdef PAWN_DOUBLE_STEP_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif

  move_option_generator dut (
    .clk              (clk),
    .reset            (reset),
    .update           (update),
    .selectedPosition (selectedPosition),
    .boardData        (boardData),
    .ready            (ready),
    .moveOptions      (moveOptions),
    .dbg_state        (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic clear_board();
    boardData = '0;
  endtask

  task automatic put(input int sq, input logic [3:0] pc);
    boardData[sq*4 +: 4] = pc;
  endtask

  task automatic start_scan(input logic [5:0] sq);
    @(negedge clk);
    update           = 1'b1;
    selectedPosition = sq;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  // Edges after the sampling edge until ready is seen high; -1 on timeout.
  task automatic wait_ready(output int edges);
    edges = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic run_case(input string tag, input logic [5:0] sq, input logic [63:0] exp_mask,
                          input int exp_lat);
    int lat;
    exp_q.push_back(exp_mask);
    start_scan(sq);
    wait_ready(lat);
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_mask"}, moveOptions, exp_q.pop_front());
  endtask

  initial begin
    int lat;
    reset            = 1'b0;
    update           = 1'b0;
    selectedPosition = '0;
    clear_board();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_ready", 64'(ready), 64'd1);
    check_eq("reset_mask", moveOptions, 64'd0);
    check_eq("reset_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // White rook a1 on an empty board.
    put(0, W_ROOK);
    start_scan(6'd0);
    check_eq("rook_ready_drop", 64'(ready), 64'd0);
    wait_ready(lat);
    check_eq("rook_latency", 64'(lat), 64'd18);
    check_eq("rook_mask", moveOptions, 64'h0101_0101_0101_01FE);

    // White knight a1.
    clear_board();
    put(0, W_KNIGHT);
    run_case("knight", 6'd0, 64'h0000_0000_0002_0400, 10);

    // White king a1.
    clear_board();
    put(0, W_KING);
    run_case("king", 6'd0, 64'h0000_0000_0000_0302, 10);

    // White bishop d4, black pawn f6, white pawn b2.
    clear_board();
    put(27, W_BISHOP);
    put(45, B_PAWN);
    put(9, W_PAWN);
    run_case("bishop", 6'd27, 64'h0001_2214_0014_2040, 12);
    check_eq("bishop_b54", 64'(moveOptions[54]), 64'd0);
    check_eq("bishop_b63", 64'(moveOptions[63]), 64'd0);
    check_eq("bishop_b0", 64'(moveOptions[0]), 64'd0);
    check_eq("bishop_b9", 64'(moveOptions[9]), 64'd0);

    // Black queen d4, white pawn d5, black pawn b4.
    clear_board();
    put(27, B_QUEEN);
    put(35, W_PAWN);
    put(25, B_PAWN);
    run_case("queen", 6'd27, 64'h8041_221C_F41C_2A49, 25);

    // White pawn e2, black pawns d3/f3.
    clear_board();
    put(12, W_PAWN);
    put(19, B_PAWN);
    put(21, B_PAWN);
    run_case("pawn_e2", 6'd12, (DBL != 0) ? 64'h0000_0000_1038_0000 : 64'h0000_0000_0038_0000,
             5 + DBL);

    // White pawn h2, black pawn g3: right capture is off-board, no wrap to a4.
    clear_board();
    put(15, W_PAWN);
    put(22, B_PAWN);
    run_case("pawn_h2", 6'd15, (DBL != 0) ? 64'h0000_0000_80C0_0000 : 64'h0000_0000_00C0_0000,
             5 + DBL);
    check_eq("pawn_h2_b24", 64'(moveOptions[24]), 64'd0);

    // Black pawn e7, white pawns d6/f6.
    clear_board();
    put(52, B_PAWN);
    put(43, W_PAWN);
    put(45, W_PAWN);
    run_case("pawn_e7", 6'd52, (DBL != 0) ? 64'h0000_3810_0000_0000 : 64'h0000_3800_0000_0000,
             5 + DBL);

    // Empty square d5 with a rook on a1; a second update while busy is dropped.
    clear_board();
    put(0, W_ROOK);
    start_scan(6'd35);
    @(negedge clk);
    update           = 1'b1;
    selectedPosition = 6'd0;
    @(posedge clk);
    #1;
    update = 1'b0;
    check_eq("empty_busy", 64'(ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("empty_ready3", 64'(ready), 64'd1);
    check_eq("empty_mask", moveOptions, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("empty_still_idle", 64'(dbg_state), 64'd0);
    check_eq("empty_mask_held", moveOptions, 64'd0);

    // Reset in the middle of a rook scan.
    start_scan(6'd0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_ready", 64'(ready), 64'd1);
    check_eq("abort_mask", moveOptions, 64'd0);
    check_eq("abort_state", 64'(dbg_state), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("post_abort_state", 64'(dbg_state), 64'd0);
    check_eq("post_abort_mask", moveOptions, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
